// File: rtl/hls_run_ctrl_pkg.sv
// Shared types for the Bambu run controller: FSM states, run status codes
// and the accelerator reset hold length used on a watchdog abort.
package hls_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HOST_ISSUE = 3'd1,
        HOST_WAIT  = 3'd2,
        START      = 3'd3,
        RUN        = 3'd4,
        ABORT      = 3'd5,
        DONE       = 3'd6
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;

    localparam int ABORT_RST_CYCLES = 2;

    // Everything from the start pulse up to and including the done pulse.
    function automatic logic is_run_state(input state_t s);
        return (s == START) || (s == RUN) || (s == ABORT) || (s == DONE);
    endfunction

endpackage

// File: rtl/hls_slave_port_mux.sv
// Places the latched host access on channel 0 of the accelerator slave RAM
// port and picks channel 0 back out of the response; channel 1 stays idle.
module hls_slave_port_mux #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic                  issue,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [6:0]            req_size,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [13:0]           S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy,
    output logic [DATA_W-1:0]     ch0_rdata,
    output logic                  ch0_rdy
);

    // Every field is gated so the bus reads all-zero whenever no access is issued.
    assign S_oe_ram        = {1'b0, issue & ~req_we};
    assign S_we_ram        = {1'b0, issue & req_we};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, {ADDR_W{issue}} & req_addr};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, {DATA_W{issue}} & req_wdata};
    assign S_data_ram_size = {7'd0, {7{issue}} & req_size};

    assign ch0_rdata = Sout_Rdata_ram[DATA_W-1:0];
    assign ch0_rdy   = Sout_DataRdy[0];

    logic unused_ch1;
    assign unused_ch1 = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

endmodule

// File: rtl/hls_run_ctrl.sv
// Run controller for a Bambu accelerator: start/done sequencing, cycle count and
// host sharing of the slave RAM port. HLS_RUN_CTRL_WATCHDOG_EN adds a timeout abort.
module hls_run_ctrl
    import hls_run_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 64,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run_req,
    output logic                  run_busy,
    output logic                  run_done,
    output logic [1:0]            run_status,
    output logic [CNT_W-1:0]      run_cycles,
    output logic                  acc_start_port,
    input  logic                  acc_done_port,
    output logic                  acc_reset,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DATA_W-1:0]     host_wdata,
    input  logic [6:0]            host_size,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_W-1:0]     host_rdata,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [13:0]           S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy,
    output state_t                dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t              state_q, state_d;
    logic                alive_q;
    logic [CNT_W-1:0]    cnt_q, cnt_inc, run_cycles_q;
    logic                req_we_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [6:0]          req_size_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                issue, ch0_rdy;
    logic [DATA_W-1:0]   ch0_rdata;
    logic                timeout_hit, abort_last;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

`ifdef HLS_RUN_CTRL_WATCHDOG_EN
    logic [1:0] abort_cnt_q;
    logic [1:0] run_status_q;

    assign timeout_hit = (cnt_q == TIMEOUT_LIMIT);
    assign abort_last  = (state_q == ABORT) && (abort_cnt_q == 2'(ABORT_RST_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            abort_cnt_q  <= 2'd0;
            run_status_q <= ST_OK;
        end else begin
            abort_cnt_q <= (state_q == ABORT) ? abort_cnt_q + 2'd1 : 2'd0;
            if (abort_last)
                run_status_q <= ST_TIMEOUT;
            else if (((state_q == START) || (state_q == RUN)) && acc_done_port)
                run_status_q <= ST_OK;
        end
    end

    assign run_status = run_status_q;
`else
    assign timeout_hit = 1'b0;
    assign abort_last  = 1'b0;
    assign run_status  = ST_OK;
`endif

    always_comb begin
        state_d        = state_q;
        host_gnt       = 1'b0;
        issue          = 1'b0;
        acc_start_port = 1'b0;
        run_done       = 1'b0;
        case (state_q)
            // alive_q keeps the FSM parked until the accelerator leaves reset.
            IDLE: begin
                if (alive_q) begin
                    if (host_req) begin
                        host_gnt = 1'b1;
                        state_d  = HOST_ISSUE;
                    end else if (run_req) begin
                        state_d = START;
                    end
                end
            end
            HOST_ISSUE: begin
                issue   = 1'b1;
                state_d = HOST_WAIT;
            end
            HOST_WAIT: if (ch0_rdy) state_d = IDLE;
            START: begin
                acc_start_port = 1'b1;
                state_d        = acc_done_port ? DONE : RUN;
            end
            RUN: begin
                if (acc_done_port)    state_d = DONE;
                else if (timeout_hit) state_d = ABORT;
            end
            ABORT: if (abort_last) state_d = DONE;
            DONE: begin
                run_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            alive_q      <= 1'b0;
            cnt_q        <= '0;
            run_cycles_q <= '0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_size_q   <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            if (host_gnt) begin
                req_we_q    <= host_we;
                req_addr_q  <= host_addr;
                req_wdata_q <= host_wdata;
                req_size_q  <= host_size;
            end
            rvalid_q <= (state_q == HOST_WAIT) && ch0_rdy;
            if ((state_q == HOST_WAIT) && ch0_rdy)
                rdata_q <= req_we_q ? '0 : ch0_rdata;
            // run_cycles counts the START cycle through the done cycle inclusive.
            case (state_q)
                START: begin
                    cnt_q <= CNT_ONE;
                    if (acc_done_port) run_cycles_q <= CNT_ONE;
                end
                RUN: begin
                    if (acc_done_port) run_cycles_q <= cnt_inc;
                    else               cnt_q        <= cnt_inc;
                end
                ABORT: if (abort_last) run_cycles_q <= TIMEOUT_LIMIT;
                default: ;
            endcase
        end
    end

    assign run_busy    = is_run_state(state_q);
    assign acc_reset   = alive_q && (state_q != ABORT);
    assign run_cycles  = run_cycles_q;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;
    assign dbg_state   = state_q;

    hls_slave_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .issue           (issue),
        .req_we          (req_we_q),
        .req_addr        (req_addr_q),
        .req_wdata       (req_wdata_q),
        .req_size        (req_size_q),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy),
        .ch0_rdata       (ch0_rdata),
        .ch0_rdy         (ch0_rdy)
    );

endmodule

// File: tb/tb_hls_run_ctrl.sv
// Self-checking bench for hls_run_ctrl: vector tables for runs and host accesses,
// randomized traffic against a cycle-count/memory model, and reset/priority corner cases.
module tb_hls_run_ctrl;
    import hls_run_ctrl_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 64;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 50;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                clock, reset;
    logic                run_req, run_busy, run_done;
    logic [1:0]          run_status;
    logic [CNT_W-1:0]    run_cycles;
    logic                acc_start_port, acc_done_port, acc_reset;
    logic                host_req, host_we, host_gnt, host_rvalid;
    logic [ADDR_W-1:0]   host_addr;
    logic [DATA_W-1:0]   host_wdata, host_rdata;
    logic [6:0]          host_size;
    logic [1:0]          S_oe_ram, S_we_ram, Sout_DataRdy;
    logic [2*ADDR_W-1:0] S_addr_ram;
    logic [2*DATA_W-1:0] S_Wdata_ram, Sout_Rdata_ram;
    logic [13:0]         S_data_ram_size;
    state_t              dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_mem[int];
    logic [DATA_W-1:0] slave_mem[int];

    typedef struct {
        int               delay;
        logic [CNT_W-1:0] exp_cycles;
    } run_vec_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [6:0]        size;
        int                rdy;
        logic [DATA_W-1:0] exp_rdata;
    } host_vec_t;

    run_vec_t  run_tab[5];
    host_vec_t host_tab[5];

    hls_run_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .run_req         (run_req),
        .run_busy        (run_busy),
        .run_done        (run_done),
        .run_status      (run_status),
        .run_cycles      (run_cycles),
        .acc_start_port  (acc_start_port),
        .acc_done_port   (acc_done_port),
        .acc_reset       (acc_reset),
        .host_req        (host_req),
        .host_we         (host_we),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_size       (host_size),
        .host_gnt        (host_gnt),
        .host_rvalid     (host_rvalid),
        .host_rdata      (host_rdata),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy),
        .dbg_state       (dbg_state)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // A run lasts from the start cycle through the done cycle inclusive.
    function automatic logic [CNT_W-1:0] model_cycles(input int delay);
        int n;
        n = delay + 1;
        if (n > int'(CNT_MAX)) return CNT_MAX;
        return CNT_W'(n);
    endfunction

    // Drives one run; the accelerator raises done `delay` cycles after its start pulse.
    task automatic do_run(input int delay, input logic [CNT_W-1:0] exp_cycles,
                          input bit hold_host, input string tag);
        bit seen;
        int waited, extra_starts, early_done, gnt_seen;
        seen = 1'b0; waited = 0; extra_starts = 0; early_done = 0; gnt_seen = 0;
        run_req = 1'b1;
        while (!seen && waited < 8) begin
            @(negedge clock);
            waited++;
            seen = acc_start_port;
        end
        run_req = 1'b0;
        check($sformatf("%s_start_latency", tag), waited, 1);
        if (!seen) return;
        if (hold_host) begin
            host_req = 1'b1; host_we = 1'b0; host_addr = 10'h040; host_size = 7'd64;
        end
        for (int t = 0; t <= delay; t++) begin
            if (t > 0) begin
                @(negedge clock);
                extra_starts += int'(acc_start_port);
                early_done   += int'(run_done);
            end
            gnt_seen += int'(host_gnt);
            acc_done_port = (t == delay);
        end
        @(negedge clock);
        acc_done_port = 1'b0;
        gnt_seen += int'(host_gnt);
        check($sformatf("%s_done", tag), run_done, 1'b1);
        check($sformatf("%s_cycles", tag), run_cycles, exp_cycles);
        check($sformatf("%s_status", tag), run_status, ST_OK);
        check($sformatf("%s_busy", tag), run_busy, 1'b1);
        check($sformatf("%s_single_start", tag), extra_starts, 0);
        check($sformatf("%s_no_early_done", tag), early_done, 0);
        if (hold_host) check($sformatf("%s_no_gnt_in_run", tag), gnt_seen, 0);
        @(negedge clock);
        check($sformatf("%s_done_pulse", tag), {run_done, run_busy}, 2'b00);
    endtask

    // One host access; the slave answers DataRdy `rdy` cycles after the strobe cycle.
    task automatic do_host(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [6:0] size,
                           input int rdy, input logic [DATA_W-1:0] exp_rdata, input string tag);
        logic [ADDR_W-1:0] cap_addr;
        logic              cap_we;
        logic [DATA_W-1:0] ch0;
        int                early;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata; host_size = size;
        #1;
        check($sformatf("%s_gnt", tag), host_gnt, 1'b1);
        exp_q.push_back(exp_rdata);
        if (we) model_mem[int'(addr)] = wdata;
        @(negedge clock);
        host_req = 1'b0;
        check($sformatf("%s_strobes", tag), {S_oe_ram, S_we_ram}, {1'b0, ~we, 1'b0, we});
        check($sformatf("%s_addr", tag), S_addr_ram, {{ADDR_W{1'b0}}, addr});
        check($sformatf("%s_wdata", tag), S_Wdata_ram, {{DATA_W{1'b0}}, wdata});
        check($sformatf("%s_size", tag), S_data_ram_size, {7'd0, size});
        cap_addr = S_addr_ram[ADDR_W-1:0];
        cap_we   = S_we_ram[0];
        if (cap_we) slave_mem[int'(cap_addr)] = S_Wdata_ram[DATA_W-1:0];
        early = 0;
        for (int d = 1; d <= rdy; d++) begin
            @(negedge clock);
            early += int'(host_rvalid) + int'(|S_oe_ram) + int'(|S_we_ram);
            if (cap_we)                             ch0 = {$urandom, $urandom};
            else if (slave_mem.exists(int'(cap_addr))) ch0 = slave_mem[int'(cap_addr)];
            else                                    ch0 = '0;
            Sout_DataRdy   = {1'($urandom_range(0, 1)), (d == rdy)};
            Sout_Rdata_ram = {$urandom, $urandom, ch0};
        end
        @(negedge clock);
        Sout_DataRdy = 2'b00;
        check($sformatf("%s_rvalid", tag), host_rvalid, 1'b1);
        check($sformatf("%s_rdata", tag), host_rdata, exp_q.pop_front());
        check($sformatf("%s_quiet_wait", tag), early, 0);
    endtask

    initial begin
        int                dn, wd_low;
        bit                wd_got;
        logic              rw;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd, re;

        run_tab[0] = '{10,  8'd11};
        run_tab[1] = '{0,   8'd1};
        run_tab[2] = '{1,   8'd2};
        run_tab[3] = '{254, 8'd255};
        run_tab[4] = '{270, 8'd255};
        host_tab[0] = '{1'b1, 10'h040, 64'h0000_0000_DEAD_BEEF, 7'd32, 2, 64'h0};
        host_tab[1] = '{1'b0, 10'h040, 64'h0,                   7'd32, 2, 64'h0000_0000_DEAD_BEEF};
        host_tab[2] = '{1'b1, 10'h3F8, 64'h0123_4567_89AB_CDEF, 7'd64, 1, 64'h0};
        host_tab[3] = '{1'b0, 10'h3F8, 64'h0,                   7'd64, 3, 64'h0123_4567_89AB_CDEF};
        host_tab[4] = '{1'b0, 10'h040, 64'h0,                   7'd64, 1, 64'h0000_0000_DEAD_BEEF};

        reset = 1'b0; run_req = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = '0;
        host_wdata = '0; host_size = '0; acc_done_port = 1'b0;
        Sout_DataRdy = 2'b00; Sout_Rdata_ram = '0;
        repeat (2) @(negedge clock);
        check("rst_ctrl", {run_busy, run_done, run_status, run_cycles, acc_start_port,
                           acc_reset, host_gnt, host_rvalid, dbg_state}, '0);
        check("rst_slave", {S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
                            host_rdata}, '0);
        run_req = 1'b0; host_req = 1'b0;
        reset = 1'b1;
        #1 check("rst_acc_held", acc_reset, 1'b0);
        @(negedge clock);
        check("rst_acc_release", acc_reset, 1'b1);

        foreach (run_tab[i]) begin
`ifdef HLS_RUN_CTRL_WATCHDOG_EN
            if (run_tab[i].delay >= TIMEOUT) continue;
`endif
            do_run(run_tab[i].delay, run_tab[i].exp_cycles, 1'b0, $sformatf("tab_run%0d", i));
        end

        foreach (host_tab[i])
            do_host(host_tab[i].we, host_tab[i].addr, host_tab[i].wdata, host_tab[i].size,
                    host_tab[i].rdy, host_tab[i].exp_rdata, $sformatf("tab_host%0d", i));

        // Host and run requested together: host first, start right after rvalid.
        run_req = 1'b1;
        do_host(1'b1, 10'h100, 64'h5555_AAAA_5555_AAAA, 7'd64, 1, 64'h0, "prio_host");
        check("prio_no_start_during_host", acc_start_port, 1'b0);
        do_run(3, model_cycles(3), 1'b0, "prio_run");

        // Host request raised mid-run is only granted once back in IDLE.
        do_run(6, model_cycles(6), 1'b1, "hold_run");
        do_host(1'b0, 10'h040, 64'h0, 7'd64, 2, 64'h0000_0000_DEAD_BEEF, "hold_host");

        for (int i = 0; i < 6; i++) begin
            dn = $urandom_range(0, 40);
            do_run(dn, model_cycles(dn), 1'b0, $sformatf("rnd_run%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = ADDR_W'($urandom_range(0, 3) * 8);
            rd = {$urandom, $urandom};
            if (rw)                          re = '0;
            else if (model_mem.exists(int'(ra))) re = model_mem[int'(ra)];
            else                             re = '0;
            do_host(rw, ra, rd, 7'd64, $urandom_range(1, 4), re, $sformatf("rnd_host%0d", i));
        end

        // Reset in the middle of a run aborts it silently.
        run_req = 1'b1;
        @(negedge clock);
        run_req = 1'b0;
        check("mr_start", acc_start_port, 1'b1);
        repeat (4) @(negedge clock);
        check("mr_busy", run_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mr_rst_ctrl", {run_busy, run_done, run_status, run_cycles, acc_start_port,
                              acc_reset, host_gnt, host_rvalid, dbg_state}, '0);
        dn = 0;
        repeat (3) begin
            @(negedge clock);
            dn += int'(run_done);
        end
        check("mr_no_done", dn, 0);
        reset = 1'b1;
        @(negedge clock);
        check("mr_acc_release", acc_reset, 1'b1);
        do_run(5, model_cycles(5), 1'b0, "mr_after");

`ifdef HLS_RUN_CTRL_WATCHDOG_EN
        run_req = 1'b1;
        @(negedge clock);
        run_req = 1'b0;
        check("wd_start", acc_start_port, 1'b1);
        wd_low = 0; wd_got = 1'b0;
        for (int i = 0; i < 120 && !wd_got; i++) begin
            @(negedge clock);
            wd_low += int'(!acc_reset);
            wd_got  = run_done;
        end
        check("wd_done", wd_got, 1'b1);
        check("wd_acc_reset_low", wd_low, ABORT_RST_CYCLES);
        check("wd_status", run_status, ST_TIMEOUT);
        check("wd_cycles", run_cycles, CNT_W'(TIMEOUT));
        @(negedge clock);
`else
        wd_low = 0; wd_got = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
